// File: rtl/lock_access_ctrl_if.sv
// Requester-side and lock-side signals of the combination-lock access controller.
interface lock_access_ctrl_if #(
   parameter int CODE_BYTES = 3
);
   logic [1:0]              req;
   logic [8*CODE_BYTES-1:0] attempt0;
   logic [8*CODE_BYTES-1:0] attempt1;
   logic [1:0]              grant;
   logic                    done;
   logic                    pass;
   logic                    lock_rst_n;
   logic [7:0]              lock_code;
   logic                    lock_unlocked;
   logic                    locked_out;
   logic [1:0]              fail_cnt;

   modport slave (
      input  req, attempt0, attempt1, lock_unlocked,
      output grant, done, pass, lock_rst_n, lock_code, locked_out, fail_cnt
   );

   modport master (
      output req, attempt0, attempt1, lock_unlocked,
      input  grant, done, pass, lock_rst_n, lock_code, locked_out, fail_cnt
   );
endinterface

// File: rtl/lock_access_ctrl.sv
// Arbitrates two requesters onto a shared byte-serial combination lock, sequences
// clear/feed/wait for each granted attempt, reports pass/fail and enforces a
// timed lockout after too many consecutive failures. All outputs are registered.
module lock_access_ctrl #(
   parameter int CODE_BYTES  = 3,
   parameter int WAIT_CYC    = 4,
   parameter int MAX_FAILS   = 3,
   parameter int LOCKOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   lock_access_ctrl_if.slave bus
);
   localparam int AW    = 8 * CODE_BYTES;
   localparam int IDX_W = $clog2(CODE_BYTES + 1);
   localparam int WT_W  = $clog2(WAIT_CYC + 1);
   localparam int LO_W  = $clog2(LOCKOUT_CYC + 1);
   localparam logic [1:0] FC_MAX = 2'(MAX_FAILS);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_RESULT, S_LOCKOUT
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             lock_rst_n_q, lock_rst_n_d;
   logic [7:0]       lock_code_q, lock_code_d;
   logic             locked_out_q, locked_out_d;
   logic [1:0]       fail_cnt_q, fail_cnt_d;
   logic             ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WT_W-1:0]  wait_q, wait_d;
   logic [LO_W-1:0]  lo_q, lo_d;
   logic [AW-1:0]    attempt_q, attempt_d;
   logic             win;

   // Byte k of the latched word, byte 0 being the most significant.
   function automatic logic [7:0] code_byte(input logic [AW-1:0] w, input logic [IDX_W-1:0] k);
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < CODE_BYTES; i++) begin
         if (k == IDX_W'(i)) b = w[8*(CODE_BYTES-1-i) +: 8];
      end
      return b;
   endfunction

   // Round-robin winner: the pointed-to requester if asking, otherwise the other one.
   assign win = bus.req[ptr_q] ? ptr_q : ~ptr_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decision.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (|bus.req) state_d = S_CLEAR;
         S_CLEAR:   state_d = S_FEED;
         S_FEED:    if (idx_q == IDX_W'(CODE_BYTES)) state_d = S_WAIT;
         S_WAIT:    if (bus.lock_unlocked || (wait_q == WT_W'(WAIT_CYC - 1))) state_d = S_RESULT;
         S_RESULT:  state_d = (fail_cnt_q == FC_MAX) ? S_LOCKOUT : S_IDLE;
         S_LOCKOUT: if (lo_q == '0) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and counters, keyed on the transition taken.
   always_comb begin
      grant_d      = grant_q;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      lock_rst_n_d = 1'b1;
      lock_code_d  = 8'h00;
      locked_out_d = 1'b0;
      fail_cnt_d   = fail_cnt_q;
      ptr_d        = ptr_q;
      idx_d        = idx_q;
      wait_d       = wait_q;
      lo_d         = lo_q;
      attempt_d    = attempt_q;
      case (state_q)
         S_IDLE: begin
            if (state_d == S_CLEAR) begin
               grant_d      = win ? 2'b10 : 2'b01;
               ptr_d        = ~win;
               idx_d        = '0;
               attempt_d    = win ? bus.attempt1 : bus.attempt0;
               lock_rst_n_d = 1'b0;
            end
         end
         S_CLEAR: begin
            lock_code_d = code_byte(attempt_q, idx_q);
            idx_d       = idx_q + IDX_W'(1);
         end
         S_FEED: begin
            if (state_d == S_WAIT) begin
               wait_d = '0;
            end else begin
               lock_code_d = code_byte(attempt_q, idx_q);
               idx_d       = idx_q + IDX_W'(1);
            end
         end
         S_WAIT: begin
            if (state_d == S_RESULT) begin
               done_d = 1'b1;
               pass_d = bus.lock_unlocked;
               if (bus.lock_unlocked)          fail_cnt_d = 2'd0;
               else if (fail_cnt_q != FC_MAX)  fail_cnt_d = fail_cnt_q + 2'd1;
            end else begin
               wait_d = wait_q + WT_W'(1);
            end
         end
         S_RESULT: begin
            grant_d = 2'b00;
            if (state_d == S_LOCKOUT) begin
               lo_d         = LO_W'(LOCKOUT_CYC - 1);
               locked_out_d = 1'b1;
               lock_rst_n_d = 1'b0;
            end
         end
         S_LOCKOUT: begin
            if (state_d == S_IDLE) begin
               fail_cnt_d = 2'd0;
            end else begin
               lo_d         = lo_q - LO_W'(1);
               locked_out_d = 1'b1;
               lock_rst_n_d = 1'b0;
            end
         end
         default: grant_d = 2'b00;
      endcase
   end

   // Output and control registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q      <= 2'b00;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         lock_rst_n_q <= 1'b0;
         lock_code_q  <= 8'h00;
         locked_out_q <= 1'b0;
         fail_cnt_q   <= 2'd0;
         ptr_q        <= 1'b0;
         idx_q        <= '0;
         wait_q       <= '0;
         lo_q         <= '0;
      end else begin
         grant_q      <= grant_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         lock_rst_n_q <= lock_rst_n_d;
         lock_code_q  <= lock_code_d;
         locked_out_q <= locked_out_d;
         fail_cnt_q   <= fail_cnt_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         wait_q       <= wait_d;
         lo_q         <= lo_d;
      end
   end

   // Latched attempt word; pure data, only meaningful after a grant.
   always_ff @(posedge clk) begin
      attempt_q <= attempt_d;
   end

   assign bus.grant      = grant_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.lock_rst_n = lock_rst_n_q;
   assign bus.lock_code  = lock_code_q;
   assign bus.locked_out = locked_out_q;
   assign bus.fail_cnt   = fail_cnt_q;
endmodule

// File: tb/tb_lock_access_ctrl.sv
// Bench for lock_access_ctrl: a behavioural 3-byte lock (AA,BB,CC, unlocked flag
// two cycles after the last correct byte) and a done-scoreboard of expected
// grant/pass/fail_cnt/latency per attempt.
module tb_lock_access_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;

   lock_access_ctrl_if #(.CODE_BYTES(3)) bus ();

   lock_access_ctrl #(
      .CODE_BYTES(3), .WAIT_CYC(4), .MAX_FAILS(3), .LOCKOUT_CYC(64)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   initial forever #5 clk = ~clk;

   // Lock model.
   logic [1:0] lk_stage;
   logic       lk_unl;

   function automatic logic [7:0] key_byte(input logic [1:0] s);
      case (s)
         2'd0:    return 8'hAA;
         2'd1:    return 8'hBB;
         default: return 8'hCC;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!bus.lock_rst_n) begin
         lk_stage <= 2'd0;
         lk_unl   <= 1'b0;
      end else begin
         if (lk_stage != 2'd3) begin
            if (bus.lock_code == key_byte(lk_stage)) lk_stage <= lk_stage + 2'd1;
            else if (bus.lock_code == 8'hAA)         lk_stage <= 2'd1;
            else                                     lk_stage <= 2'd0;
         end
         lk_unl <= (lk_stage == 2'd3);
      end
   end

   assign bus.lock_unlocked = lk_unl;

   typedef struct {
      logic [1:0] grant;
      logic       pass;
      logic [1:0] fc;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Scoreboard monitor: every done pulse is matched against the oldest expectation.
   initial begin
      int   gcnt;
      exp_t e;
      gcnt = 0;
      forever begin
         @(negedge clk);
         if (bus.grant != 2'b00) gcnt++;
         else                    gcnt = 0;
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got done=1 grant=%b, want no done", bus.grant);
            end else begin
               e = sb.pop_front();
               vectors++;
               if (bus.grant !== e.grant) begin
                  miscompares++;
                  $display("FAIL done_grant: got %b want %b", bus.grant, e.grant);
               end
               vectors++;
               if (bus.pass !== e.pass) begin
                  miscompares++;
                  $display("FAIL done_pass: got %b want %b", bus.pass, e.pass);
               end
               vectors++;
               if (bus.fail_cnt !== e.fc) begin
                  miscompares++;
                  $display("FAIL done_fail_cnt: got %0d want %0d", bus.fail_cnt, e.fc);
               end
               vectors++;
               if (gcnt != e.lat) begin
                  miscompares++;
                  $display("FAIL done_latency: got %0d want %0d", gcnt, e.lat);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish within 20000 cycles");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_grant();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (bus.grant != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL grant_timeout: got grant=%b, want a grant within 120 cycles", bus.grant);
      end
   endtask

   task automatic wait_done();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL done_timeout: got done=%b, want done within 40 cycles", bus.done);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.req = 2'b00;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic run_attempt(input int who, input logic [23:0] code,
                              input logic exp_pass, input logic [1:0] exp_fc);
      sb.push_back('{(who == 0) ? 2'b01 : 2'b10, exp_pass, exp_fc, exp_pass ? 7 : 9});
      if (who == 0) begin
         bus.attempt0 = code;
         bus.req = 2'b01;
      end else begin
         bus.attempt1 = code;
         bus.req = 2'b10;
      end
      wait_grant();
      bus.req = 2'b00;
      wait_done();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      vectors++;
      if (bus.grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
      vectors++;
      if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
      vectors++;
      if (bus.pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
      vectors++;
      if (bus.lock_rst_n !== 1'b0) begin miscompares++; $display("FAIL reset_lock_rst_n: got %b want 0", bus.lock_rst_n); end
      vectors++;
      if (bus.lock_code !== 8'h00) begin miscompares++; $display("FAIL reset_lock_code: got %h want 00", bus.lock_code); end
      vectors++;
      if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL reset_locked_out: got %b want 0", bus.locked_out); end
      vectors++;
      if (bus.fail_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_fail_cnt: got %0d want 0", bus.fail_cnt); end
      reset = 1'b0;
      tick();
      vectors++;
      if (bus.lock_rst_n !== 1'b1) begin miscompares++; $display("FAIL idle_lock_rst_n: got %b want 1", bus.lock_rst_n); end
   endtask

   task automatic test_single_pass();
      logic [23:0] w;
      w = 24'hAABBCC;
      sb.push_back('{2'b01, 1'b1, 2'd0, 7});
      bus.attempt0 = w;
      bus.req = 2'b01;
      wait_grant();
      bus.req = 2'b00;
      vectors++;
      if (bus.grant !== 2'b01) begin miscompares++; $display("FAIL pass_grant: got %b want 01", bus.grant); end
      vectors++;
      if (bus.lock_rst_n !== 1'b0) begin miscompares++; $display("FAIL clear_lock_rst_n: got %b want 0", bus.lock_rst_n); end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (bus.lock_code !== w[23-8*k -: 8]) begin
            miscompares++;
            $display("FAIL feed_byte%0d: got %h want %h", k, bus.lock_code, w[23-8*k -: 8]);
         end
         vectors++;
         if (bus.lock_rst_n !== 1'b1) begin miscompares++; $display("FAIL feed_lock_rst_n: got %b want 1", bus.lock_rst_n); end
      end
      wait_done();
   endtask

   task automatic test_single_fail();
      run_attempt(1, 24'hAABBCD, 1'b0, 2'd1);
      tick();
      vectors++;
      if (bus.fail_cnt !== 2'd1) begin miscompares++; $display("FAIL fail_cnt_after_fail: got %0d want 1", bus.fail_cnt); end
      vectors++;
      if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL no_lockout_after_one: got %b want 0", bus.locked_out); end
   endtask

   task automatic test_recover();
      run_attempt(0, 24'h112233, 1'b0, 2'd2);
      run_attempt(1, 24'hAABBCC, 1'b1, 2'd0);
      run_attempt(0, 24'h112233, 1'b0, 2'd1);
      tick();
      tick();
      vectors++;
      if (bus.locked_out !== 1'b0) begin miscompares++; $display("FAIL recover_locked_out: got %b want 0", bus.locked_out); end
      vectors++;
      if (bus.fail_cnt !== 2'd1) begin miscompares++; $display("FAIL recover_fail_cnt: got %0d want 1", bus.fail_cnt); end
   endtask

   task automatic test_lockout();
      int lo_cnt;
      apply_reset();
      run_attempt(0, 24'h112233, 1'b0, 2'd1);
      run_attempt(1, 24'h112233, 1'b0, 2'd2);
      sb.push_back('{2'b01, 1'b0, 2'd3, 9});
      bus.attempt0 = 24'h112233;
      bus.req = 2'b01;
      wait_grant();
      bus.req = 2'b00;
      wait_done();
      // request held across the whole lockout
      sb.push_back('{2'b01, 1'b1, 2'd0, 7});
      bus.attempt0 = 24'hAABBCC;
      bus.req = 2'b01;
      lo_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.locked_out === 1'b1) begin
            lo_cnt++;
            vectors++;
            if (bus.grant !== 2'b00 || bus.lock_rst_n !== 1'b0) begin
               miscompares++;
               $display("FAIL lockout_hold: got grant=%b lock_rst_n=%b want 00/0", bus.grant, bus.lock_rst_n);
            end
         end else if (lo_cnt > 0) begin
            break;
         end
      end
      vectors++;
      if (lo_cnt != 64) begin miscompares++; $display("FAIL lockout_len: got %0d want 64", lo_cnt); end
      vectors++;
      if (bus.fail_cnt !== 2'd0) begin miscompares++; $display("FAIL lockout_exit_fail_cnt: got %0d want 0", bus.fail_cnt); end
      wait_grant();
      bus.req = 2'b00;
      wait_done();
   endtask

   task automatic test_back_to_back();
      int g;
      int d;
      logic [1:0] prev;
      apply_reset();
      sb.push_back('{2'b01, 1'b1, 2'd0, 7});
      sb.push_back('{2'b10, 1'b1, 2'd0, 7});
      sb.push_back('{2'b01, 1'b1, 2'd0, 7});
      bus.attempt0 = 24'hAABBCC;
      bus.attempt1 = 24'hAABBCC;
      bus.req = 2'b11;
      g = 0;
      d = 0;
      prev = 2'b00;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (bus.grant != 2'b00 && prev == 2'b00) begin
            g++;
            if (g == 3) bus.req = 2'b00;
         end
         prev = bus.grant;
         if (bus.done === 1'b1) d++;
         if (d == 3) break;
      end
      vectors++;
      if (d != 3) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 3", d); end
      repeat (4) tick();
      vectors++;
      if (bus.grant !== 2'b00) begin miscompares++; $display("FAIL b2b_no_extra_grant: got %b want 00", bus.grant); end
   endtask

   task automatic test_reset_mid();
      bus.attempt0 = 24'hAABBCC;
      bus.req = 2'b01;
      wait_grant();
      bus.req = 2'b00;
      tick();
      tick();
      vectors++;
      if (bus.lock_code !== 8'hBB) begin miscompares++; $display("FAIL mid_feed_byte: got %h want bb", bus.lock_code); end
      reset = 1'b1;
      #1;
      vectors++;
      if (bus.grant !== 2'b00) begin miscompares++; $display("FAIL mid_reset_grant: got %b want 00", bus.grant); end
      vectors++;
      if (bus.lock_rst_n !== 1'b0) begin miscompares++; $display("FAIL mid_reset_lock_rst_n: got %b want 0", bus.lock_rst_n); end
      vectors++;
      if (bus.lock_code !== 8'h00) begin miscompares++; $display("FAIL mid_reset_lock_code: got %h want 00", bus.lock_code); end
      repeat (3) begin
         tick();
         vectors++;
         if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_done: got %b want 0", bus.done); end
      end
      reset = 1'b0;
      repeat (12) tick();
      run_attempt(0, 24'hAABBCC, 1'b1, 2'd0);
   endtask

   initial begin
      bus.req = 2'b00;
      bus.attempt0 = '0;
      bus.attempt1 = '0;
      test_reset();
      test_single_pass();
      test_single_fail();
      test_recover();
      test_lockout();
      test_back_to_back();
      test_reset_mid();
      repeat (3) tick();
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
